// File: rtl/lock_code_sender.sv
// Serial code transmitter for the digital-lock FSM: sends a parallel code MSB-first,
// frame-aligned to the lock, and reports its response. Optional lockout: `define LOCKOUT_EN.
`timescale 1ns/1ps
module lock_code_sender #(
    parameter int CODE_W         = 4,
    parameter int MAX_TRIES      = 3,
    parameter int LOCKOUT_FRAMES = 8
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              start,
    input  logic [CODE_W-1:0] code,
    output logic              B,
    input  logic              correct,
    input  logic              incorrect,
    output logic              busy,
    output logic              done,
    output logic              granted,
    output logic              denied,
    output logic              no_resp,
    output logic              locked_out
);

    localparam int PH_W = $clog2(CODE_W + 1);
    localparam logic [PH_W-1:0] LAST_PH = PH_W'(CODE_W);
    localparam logic [PH_W-1:0] LAST_BIT_PH = PH_W'(CODE_W - 1);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_SEND, S_CHECK, S_LOCKOUT} state_t;

    state_t            r_state, w_state_next;
    logic [PH_W-1:0]   r_phase;
    logic [CODE_W-1:0] r_shift;
    logic              r_b, r_done, r_granted, r_denied, r_no_resp;

    logic              w_frame_end, w_latch, w_shift_en, w_check_end;
    logic              w_grant, w_no_resp;
    logic [CODE_W-1:0] w_src;

    assign w_frame_end = (r_phase == LAST_PH);
    assign w_check_end = (r_state == S_CHECK) && w_frame_end;
    assign w_grant     = correct & ~incorrect;
    assign w_no_resp   = ~correct & ~incorrect;
    // From IDLE the first bit comes straight off the input; otherwise from the latched copy.
    assign w_src       = (r_state == S_IDLE) ? code : r_shift;

`ifdef LOCKOUT_EN
    localparam int FAIL_W = $clog2(MAX_TRIES + 1);
    localparam int LOCK_W = $clog2(LOCKOUT_FRAMES + 1);

    logic [FAIL_W-1:0] r_fail;
    logic [LOCK_W-1:0] r_lock_cnt;
    logic              w_lock_exit;

    assign w_lock_exit = (r_state == S_LOCKOUT) && w_frame_end
                         && (r_lock_cnt == LOCK_W'(LOCKOUT_FRAMES - 1));

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_fail     <= '0;
            r_lock_cnt <= '0;
        end else begin
            if (w_check_end) begin
                if (w_grant)
                    r_fail <= '0;
                else if (r_fail != FAIL_W'(MAX_TRIES))
                    r_fail <= r_fail + 1'b1;
            end else if (w_lock_exit) begin
                r_fail <= '0;
            end
            if (r_state != S_LOCKOUT || w_lock_exit)
                r_lock_cnt <= '0;
            else if (w_frame_end)
                r_lock_cnt <= r_lock_cnt + 1'b1;
        end
    end

    assign locked_out = (r_state == S_LOCKOUT);
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^{32'(MAX_TRIES), 32'(LOCKOUT_FRAMES)};
    assign locked_out   = 1'b0;
`endif

    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    // NOTE: every combinational output gets a default first, so no path infers a latch.
    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        w_shift_en   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_frame_end) begin
                        w_state_next = S_SEND;
                        w_shift_en   = 1'b1;
                    end else begin
                        w_state_next = S_WAIT;
                        w_latch      = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (w_frame_end) begin
                    w_state_next = S_SEND;
                    w_shift_en   = 1'b1;
                end
            end
            S_SEND: begin
                if (r_phase == LAST_BIT_PH)
                    w_state_next = S_CHECK;
                else
                    w_shift_en   = 1'b1;
            end
            S_CHECK: begin
                if (w_frame_end) begin
                    w_state_next = S_IDLE;
`ifdef LOCKOUT_EN
                    if (!w_grant && r_fail == FAIL_W'(MAX_TRIES - 1))
                        w_state_next = S_LOCKOUT;
`endif
                end
            end
            S_LOCKOUT: begin
`ifdef LOCKOUT_EN
                if (w_lock_exit) w_state_next = S_IDLE;
`else
                w_state_next = S_IDLE;
`endif
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_phase   <= '0;
            r_shift   <= '0;
            r_b       <= 1'b0;
            r_done    <= 1'b0;
            r_granted <= 1'b0;
            r_denied  <= 1'b0;
            r_no_resp <= 1'b0;
        end else begin
            r_phase <= w_frame_end ? '0 : r_phase + 1'b1;
            if (w_latch)
                r_shift <= code;
            else if (w_shift_en)
                r_shift <= {w_src[CODE_W-2:0], 1'b0};
            r_b       <= w_shift_en ? w_src[CODE_W-1] : 1'b0;
            r_done    <= w_check_end;
            r_granted <= w_check_end & w_grant;
            r_denied  <= w_check_end & ~w_grant;
            r_no_resp <= w_check_end & w_no_resp;
        end
    end

    assign B       = r_b;
    assign busy    = (r_state == S_WAIT) || (r_state == S_SEND) || (r_state == S_CHECK);
    assign done    = r_done;
    assign granted = r_granted;
    assign denied  = r_denied;
    assign no_resp = r_no_resp;

endmodule

// File: tb/tb_lock_code_sender.sv
// Directed bench for lock_code_sender with a small behavioural lock (code 1010) and a stub mode.
`timescale 1ns/1ps
module tb_lock_code_sender;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] code = 4'b0000;
    logic       B, correct, incorrect, busy, done, granted, denied, no_resp, locked_out;

    int total = 0;
    int bad   = 0;
    int stub_mode = 0;   // 0: real lock, 1: both responses 0, 2: both responses 1

    logic [2:0] lk_phase;
    logic [3:0] lk_sr;

`ifdef LOCKOUT_EN
    localparam logic LK_EXP = 1'b1;
`else
    localparam logic LK_EXP = 1'b0;
`endif

    always #5 Clk = ~Clk;

    lock_code_sender dut (
        .Clk(Clk), .Reset_n(Reset_n), .start(start), .code(code), .B(B),
        .correct(correct), .incorrect(incorrect), .busy(busy), .done(done),
        .granted(granted), .denied(denied), .no_resp(no_resp), .locked_out(locked_out)
    );

    // Lock model: shifts B in phases 0..3 and answers in phase 4; secret code is 1010.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            lk_phase <= 3'd0;
            lk_sr    <= 4'd0;
        end else begin
            lk_phase <= (lk_phase == 3'd4) ? 3'd0 : lk_phase + 3'd1;
            if (lk_phase != 3'd4) lk_sr <= {lk_sr[2:0], B};
        end
    end

    always_comb begin
        correct   = 1'b0;
        incorrect = 1'b0;
        if (lk_phase == 3'd4) begin
            if (stub_mode == 2) begin
                correct   = 1'b1;
                incorrect = 1'b1;
            end else if (stub_mode == 0) begin
                correct   = (lk_sr == 4'b1010);
                incorrect = (lk_sr != 4'b1010);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Wait for phase q, pulse start, then check every cycle up to and including done.
    task automatic send(input logic [3:0] c, input int q, input logic eg, input logic ed,
                        input logic enr, input logic poke, input string tag);
        int guard = 0;
        int w, l;
        logic exp_b;
        while (lk_phase != 3'(q) && guard < 10) begin
            tick();
            guard++;
        end
        check({tag, "_phase"}, 32'(lk_phase), 32'(q));
        code  = c;
        start = 1'b1;
        tick();
        start = 1'b0;
        w = (q == 4) ? 0 : 4 - q;
        l = 6 + w;
        for (int n = 1; n <= l; n++) begin
            if (n < l) begin
                exp_b = (n > w && n <= w + 4) ? c[3 - (n - 1 - w)] : 1'b0;
                check($sformatf("%s_B%0d", tag, n), 32'(B), 32'(exp_b));
                check($sformatf("%s_busy%0d", tag, n), 32'(busy), 32'd1);
                check($sformatf("%s_idle_out%0d", tag, n),
                      32'({done, granted, denied, no_resp}), 32'd0);
                if (poke && n == 2) begin
                    start = 1'b1;
                    code  = ~c;
                end
                if (poke && n == 3) start = 1'b0;
                tick();
            end else begin
                check({tag, "_done"},    32'(done),    32'd1);
                check({tag, "_granted"}, 32'(granted), 32'(eg));
                check({tag, "_denied"},  32'(denied),  32'(ed));
                check({tag, "_no_resp"}, 32'(no_resp), 32'(enr));
                check({tag, "_busy_end"}, 32'(busy),   32'd0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw_done;
        #1;
        check("rst_outs", 32'({B, busy, done, granted, denied, no_resp, locked_out}), 32'd0);
        #21 Reset_n = 1'b1;
        tick();

        send(4'b1010, 4, 1'b1, 1'b0, 1'b0, 1'b0, "g1010_p4");
        // start presented in the done cycle (phase 0) is accepted
        send(4'b1100, 0, 1'b0, 1'b1, 1'b0, 1'b0, "d1100_p0");
        send(4'b1010, 1, 1'b1, 1'b0, 1'b0, 1'b1, "g1010_p1_poke");

        stub_mode = 1;
        send(4'b1010, 4, 1'b0, 1'b1, 1'b1, 1'b0, "noresp");
        stub_mode = 0;
        send(4'b1010, 2, 1'b1, 1'b0, 1'b0, 1'b0, "g1010_p2");
        stub_mode = 2;
        send(4'b0110, 4, 1'b0, 1'b1, 1'b0, 1'b0, "both_hi");
        stub_mode = 0;

        // Reset during SEND aborts; the next send must realign and be granted.
        while (lk_phase != 3'd4) tick();
        code  = 4'b1010;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        Reset_n = 1'b0;
        #1;
        check("mid_rst_B",    32'(B),    32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        tick();
        #2 Reset_n = 1'b1;
        saw_done = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done) saw_done = 1'b1;
        end
        check("mid_rst_no_done", 32'(saw_done), 32'd0);
        send(4'b1010, 4, 1'b1, 1'b0, 1'b0, 1'b0, "realign");

        for (int i = 0; i < 3; i++) begin
            send(4'b0000, 4, 1'b0, 1'b1, 1'b0, 1'b0, $sformatf("wrong%0d", i));
            check($sformatf("lk_after%0d", i), 32'(locked_out), (i == 2) ? 32'(LK_EXP) : 32'd0);
        end
`ifdef LOCKOUT_EN
        for (int k = 1; k <= 39; k++) begin
            tick();
            if (k == 10) begin
                code  = 4'b1010;
                start = 1'b1;
            end
            if (k == 15) start = 1'b0;
            if (k >= 10 && k <= 16) check($sformatf("lk_busy%0d", k), 32'(busy), 32'd0);
            if (k == 39) check("lk_last_cycle", 32'(locked_out), 32'd1);
        end
        tick();
        check("lk_released", 32'(locked_out), 32'd0);
        check("lk_rel_busy", 32'(busy), 32'd0);
        send(4'b1010, 4, 1'b1, 1'b0, 1'b0, 1'b0, "after_lockout");
`else
        send(4'b1010, 4, 1'b1, 1'b0, 1'b0, 1'b0, "no_lockout");
        check("no_lockout_lk", 32'(locked_out), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
